// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the bus adapter's single command port between the IFU and the LSU.
// One transaction in flight at a time; LSU has priority, a starved IFU fetch wins after MAX_WAIT losses.
module mem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_ifu_read,
  input  logic [63:0] i_ifu_address,
  output logic [31:0] o_ifu_readdata,
  output logic        o_ifu_done,
  input  logic        i_lsu_read,
  input  logic        i_lsu_write,
  input  logic [63:0] i_lsu_address,
  input  logic [1:0]  i_lsu_datasize,
  input  logic [63:0] i_lsu_writedata,
  output logic [63:0] o_lsu_readdata,
  output logic        o_lsu_done,
  output logic [63:0] o_mem_address,
  output logic [1:0]  o_mem_datasize,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [63:0] o_mem_writedata,
  input  logic [63:0] i_mem_readdata,
  input  logic        i_mem_done,
  output logic        o_owner,
  output logic        o_busy
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic             w_pend_i;
  logic             w_pend_l;
  logic             w_ifu_wins;
  logic             w_grant;
  logic             w_complete;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [63:0]      r_mem_address;
  logic [1:0]       r_mem_datasize;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [63:0]      r_mem_writedata;
  logic             r_owner;
  logic             r_busy;

  assign w_pend_i   = i_ifu_read;
  assign w_pend_l   = i_lsu_read | i_lsu_write;
  assign w_ifu_wins = w_pend_i & (~w_pend_l | (r_wait_cnt >= MAX_WAIT_C));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, grant/complete strobes and owner-steered done pulses
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_complete   = 1'b0;
    o_ifu_done   = 1'b0;
    o_lsu_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_i | w_pend_l) begin
          w_grant      = 1'b1;
          w_next_state = ST_BUSY;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (i_mem_done) begin
          w_complete   = 1'b1;
          w_next_state = ST_IDLE;
          o_ifu_done   = ~r_owner;
          o_lsu_done   = r_owner;
        end else begin
          w_next_state = ST_BUSY;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign o_ifu_readdata = o_ifu_done ? i_mem_readdata[31:0] : 32'd0;
  assign o_lsu_readdata = o_lsu_done ? i_mem_readdata : 64'd0;

  // Command registers: latched at the grant edge, strobes dropped at the completion edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_address   <= 64'd0;
      r_mem_datasize  <= 2'd0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_writedata <= 64'd0;
      r_owner         <= 1'b0;
      r_busy          <= 1'b0;
    end else if (w_grant) begin
      r_busy <= 1'b1;
      if (w_ifu_wins) begin
        r_mem_address   <= {i_ifu_address[63:2], 2'b00};
        r_mem_datasize  <= 2'd2;
        r_mem_read      <= 1'b1;
        r_mem_write     <= 1'b0;
        r_mem_writedata <= 64'd0;
        r_owner         <= 1'b0;
      end else begin
        // A simultaneous read and write request is served as a read
        r_mem_address   <= i_lsu_address;
        r_mem_datasize  <= i_lsu_datasize;
        r_mem_read      <= i_lsu_read;
        r_mem_write     <= i_lsu_write & ~i_lsu_read;
        r_mem_writedata <= i_lsu_writedata;
        r_owner         <= 1'b1;
      end
    end else if (w_complete) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
    end
  end

  // IFU starvation counter, only updated at grant edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= {CNT_W{1'b0}};
    end else if (w_grant) begin
      if (w_ifu_wins) begin
        r_wait_cnt <= {CNT_W{1'b0}};
      end else if (w_pend_i && (r_wait_cnt != CNT_SAT)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  assign o_mem_address   = r_mem_address;
  assign o_mem_datasize  = r_mem_datasize;
  assign o_mem_read      = r_mem_read;
  assign o_mem_write     = r_mem_write;
  assign o_mem_writedata = r_mem_writedata;
  assign o_owner         = r_owner;
  assign o_busy          = r_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: single-grant vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_read;
  logic [63:0] ifu_address;
  logic [31:0] ifu_readdata;
  logic        ifu_done;
  logic        lsu_read;
  logic        lsu_write;
  logic [63:0] lsu_address;
  logic [1:0]  lsu_datasize;
  logic [63:0] lsu_writedata;
  logic [63:0] lsu_readdata;
  logic        lsu_done;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata;
  logic        mem_done;
  logic        owner;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_ifu_read(ifu_read), .i_ifu_address(ifu_address),
    .o_ifu_readdata(ifu_readdata), .o_ifu_done(ifu_done),
    .i_lsu_read(lsu_read), .i_lsu_write(lsu_write), .i_lsu_address(lsu_address),
    .i_lsu_datasize(lsu_datasize), .i_lsu_writedata(lsu_writedata),
    .o_lsu_readdata(lsu_readdata), .o_lsu_done(lsu_done),
    .o_mem_address(mem_address), .o_mem_datasize(mem_datasize),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_writedata(mem_writedata),
    .i_mem_readdata(mem_readdata), .i_mem_done(mem_done),
    .o_owner(owner), .o_busy(busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_read      = 1'b0;
    ifu_address   = 64'd0;
    lsu_read      = 1'b0;
    lsu_write     = 1'b0;
    lsu_address   = 64'd0;
    lsu_datasize  = 2'd0;
    lsu_writedata = 64'd0;
    mem_readdata  = 64'd0;
    mem_done      = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        ifu_rd;
    logic        lsu_rd;
    logic        lsu_wr;
    logic [63:0] ifu_addr;
    logic [63:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic [63:0] lsu_wdata;
    logic [63:0] rdata;
    logic        exp_busy;
    logic        exp_owner;
    logic        exp_rd;
    logic        exp_wr;
    logic [63:0] exp_addr;
    logic [1:0]  exp_size;
  } vec_t;

  vec_t vt[8];

  // reference model state for the random phase
  logic        m_busy, m_owner, m_rd, m_wr, m_wv;
  logic [63:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  int          m_wait;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 64'h1003, 64'h0, 2'd0, 64'h0, 64'h0000_0000_DEAD_BEEF,
              1'b1, 1'b0, 1'b1, 1'b0, 64'h1000, 2'd2};
    vt[1] = '{1'b0, 1'b0, 1'b1, 64'h0, 64'h2006, 2'd1, 64'hABCD, 64'h1234,
              1'b1, 1'b1, 1'b0, 1'b1, 64'h2006, 2'd1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h3000, 2'd3, 64'h55, 64'hCAFE_F00D_0123_4567,
              1'b1, 1'b1, 1'b1, 1'b0, 64'h3000, 2'd3};
    vt[3] = '{1'b1, 1'b1, 1'b0, 64'h4004, 64'h5008, 2'd2, 64'h0, 64'h8765_4321_0FED_CBA9,
              1'b1, 1'b1, 1'b1, 1'b0, 64'h5008, 2'd2};
    vt[4] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
              1'b1, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3};
    vt[5] = '{1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'd0, 64'h0, 64'h1111_2222_3333_4444,
              1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd2};
    vt[6] = '{1'b0, 1'b0, 1'b0, 64'h7000, 64'h8000, 2'd1, 64'h0, 64'h9999,
              1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 2'd0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 64'h0, 64'h9001, 2'd0, 64'h5A, 64'h0,
              1'b1, 1'b1, 1'b0, 1'b1, 64'h9001, 2'd0};

    // Reset with a pending fetch: everything low, then a grant one cycle after release
    reset_n = 1'b0;
    idle_inputs();
    ifu_read    = 1'b1;
    ifu_address = 64'h3;
    step();
    chk("rst_mem_read", mem_read, 64'd0);
    chk("rst_mem_write", mem_write, 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_mem_datasize", mem_datasize, 64'd0);
    chk("rst_mem_writedata", mem_writedata, 64'd0);
    chk("rst_owner", owner, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_ifu_done", ifu_done, 64'd0);
    chk("rst_lsu_done", lsu_done, 64'd0);
    reset_n = 1'b1;
    step();
    chk("rst_release_read", mem_read, 64'd1);
    chk("rst_release_addr", mem_address, 64'd0);
    ifu_read = 1'b0;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;

    // Table: one grant from a fresh reset, then a single-cycle completion
    for (int v = 0; v < 8; v++) begin
      do_reset();
      ifu_read      = vt[v].ifu_rd;
      lsu_read      = vt[v].lsu_rd;
      lsu_write     = vt[v].lsu_wr;
      ifu_address   = vt[v].ifu_addr;
      lsu_address   = vt[v].lsu_addr;
      lsu_datasize  = vt[v].lsu_size;
      lsu_writedata = vt[v].lsu_wdata;
      mem_readdata  = vt[v].rdata;
      step();
      chk($sformatf("vec%0d_busy", v), busy, 64'(vt[v].exp_busy));
      chk($sformatf("vec%0d_read", v), mem_read, 64'(vt[v].exp_rd));
      chk($sformatf("vec%0d_write", v), mem_write, 64'(vt[v].exp_wr));
      chk($sformatf("vec%0d_addr", v), mem_address, vt[v].exp_addr);
      chk($sformatf("vec%0d_size", v), mem_datasize, 64'(vt[v].exp_size));
      if (vt[v].exp_busy) chk($sformatf("vec%0d_owner", v), owner, 64'(vt[v].exp_owner));
      if (vt[v].exp_busy && vt[v].exp_owner) chk($sformatf("vec%0d_wdata", v), mem_writedata, vt[v].lsu_wdata);
      ifu_read  = 1'b0;
      lsu_read  = 1'b0;
      lsu_write = 1'b0;
      mem_done  = 1'b1;
      #1;
      chk($sformatf("vec%0d_ifu_done", v), ifu_done, 64'(vt[v].exp_busy & ~vt[v].exp_owner));
      chk($sformatf("vec%0d_lsu_done", v), lsu_done, 64'(vt[v].exp_busy & vt[v].exp_owner));
      if (vt[v].exp_busy && !vt[v].exp_owner) chk($sformatf("vec%0d_ifu_rdata", v), ifu_readdata, 64'(vt[v].rdata[31:0]));
      if (vt[v].exp_busy && vt[v].exp_owner) chk($sformatf("vec%0d_lsu_rdata", v), lsu_readdata, vt[v].rdata);
      step();
      mem_done = 1'b0;
      #1;
      chk($sformatf("vec%0d_busy_after", v), busy, 64'd0);
      chk($sformatf("vec%0d_read_after", v), mem_read, 64'd0);
      chk($sformatf("vec%0d_write_after", v), mem_write, 64'd0);
    end

    // IFU fetch with the adapter answering 3 cycles after mem_read rises
    do_reset();
    ifu_read    = 1'b1;
    ifu_address = 64'h1003;
    step();
    chk("fetch_addr", mem_address, 64'h1000);
    chk("fetch_size", mem_datasize, 64'd2);
    chk("fetch_read", mem_read, 64'd1);
    for (int c = 0; c < 3; c++) begin
      chk("fetch_early_done", ifu_done, 64'd0);
      step();
    end
    mem_done     = 1'b1;
    mem_readdata = 64'h0000_0000_DEAD_BEEF;
    ifu_read     = 1'b0;
    #1;
    chk("fetch_done", ifu_done, 64'd1);
    chk("fetch_rdata", ifu_readdata, 64'hDEAD_BEEF);
    chk("fetch_lsu_done", lsu_done, 64'd0);
    step();
    mem_done = 1'b0;
    #1;
    chk("fetch_done_drop", ifu_done, 64'd0);
    chk("fetch_read_drop", mem_read, 64'd0);

    // LSU store; address changed mid-transaction must not leak through
    do_reset();
    lsu_write     = 1'b1;
    lsu_datasize  = 2'd1;
    lsu_address   = 64'h2006;
    lsu_writedata = 64'hABCD;
    step();
    chk("store_write", mem_write, 64'd1);
    chk("store_read", mem_read, 64'd0);
    lsu_address   = 64'hDEAD_0000;
    lsu_writedata = 64'h1111;
    step();
    chk("store_addr_hold", mem_address, 64'h2006);
    chk("store_wdata_hold", mem_writedata, 64'hABCD);
    mem_done  = 1'b1;
    lsu_write = 1'b0;
    #1;
    chk("store_lsu_done", lsu_done, 64'd1);
    chk("store_ifu_done", ifu_done, 64'd0);
    step();
    mem_done = 1'b0;
    #1;
    chk("store_write_drop", mem_write, 64'd0);
    chk("store_busy_drop", busy, 64'd0);

    // Both requesters held: LSU priority with the starvation guard, idle gap between grants
    begin
      int   grants = 0;
      int   losses = 0;
      logic prev_busy = 1'b0;
      logic prev_done = 1'b0;
      logic exp_owner;
      do_reset();
      ifu_read = 1'b1;
      lsu_read = 1'b1;
      for (int c = 0; c < 40 && grants < 10; c++) begin
        step();
        if (prev_done) chk("idle_gap", mem_read, 64'd0);
        if (busy && !prev_busy) begin
          exp_owner = (losses >= MAX_WAIT) ? 1'b0 : 1'b1;
          losses    = exp_owner ? losses + 1 : 0;
          chk($sformatf("grant%0d_owner", grants), owner, 64'(exp_owner));
          chk($sformatf("grant%0d_read", grants), mem_read, 64'd1);
          grants++;
        end
        prev_busy = busy;
        mem_done  = busy;
        prev_done = mem_done;
      end
      chk("grant_count", 64'(grants), 64'd10);
      idle_inputs();
      step();
    end

    // Reset while busy: strobes drop at once, no done pulse, normal arbitration afterwards
    do_reset();
    lsu_read    = 1'b1;
    lsu_address = 64'h6000;
    step();
    chk("abort_read_before", mem_read, 64'd1);
    lsu_read = 1'b0;
    mem_done = 1'b1;
    reset_n  = 1'b0;
    #1;
    chk("abort_read", mem_read, 64'd0);
    chk("abort_busy", busy, 64'd0);
    chk("abort_lsu_done", lsu_done, 64'd0);
    step();
    mem_done      = 1'b0;
    reset_n       = 1'b1;
    lsu_write     = 1'b1;
    lsu_address   = 64'h7000;
    lsu_datasize  = 2'd3;
    lsu_writedata = 64'h0123_4567_89AB_CDEF;
    step();
    chk("abort_regrant_write", mem_write, 64'd1);
    chk("abort_regrant_addr", mem_address, 64'h7000);
    chk("abort_regrant_owner", owner, 64'd1);
    lsu_write = 1'b0;
    mem_done  = 1'b1;
    step();
    mem_done = 1'b0;

    // Random traffic against a transaction-level model
    do_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_wv = 1'b0;
    m_addr = 64'd0; m_wdata = 64'd0; m_size = 2'd0; m_wait = 0;
    for (int c = 0; c < 800; c++) begin
      logic pend_i, pend_l;
      ifu_read      = 1'($urandom_range(0, 1));
      lsu_read      = ($urandom_range(0, 3) == 0);
      lsu_write     = ($urandom_range(0, 2) == 0);
      ifu_address   = {$urandom, $urandom};
      lsu_address   = {$urandom, $urandom};
      lsu_datasize  = 2'($urandom_range(0, 3));
      lsu_writedata = {$urandom, $urandom};
      mem_readdata  = {$urandom, $urandom};
      mem_done      = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      #1;
      chk("rnd_busy", busy, 64'(m_busy));
      chk("rnd_read", mem_read, 64'(m_rd));
      chk("rnd_write", mem_write, 64'(m_wr));
      chk("rnd_addr", mem_address, m_addr);
      chk("rnd_size", mem_datasize, 64'(m_size));
      if (m_busy) chk("rnd_owner", owner, 64'(m_owner));
      if (m_wv) chk("rnd_wdata", mem_writedata, m_wdata);
      chk("rnd_ifu_done", ifu_done, 64'(m_busy & ~m_owner & mem_done));
      chk("rnd_lsu_done", lsu_done, 64'(m_busy & m_owner & mem_done));
      if (m_busy && mem_done && !m_owner) chk("rnd_ifu_rdata", ifu_readdata, 64'(mem_readdata[31:0]));
      if (m_busy && mem_done && m_owner) chk("rnd_lsu_rdata", lsu_readdata, mem_readdata);
      pend_i = ifu_read;
      pend_l = lsu_read | lsu_write;
      if (m_busy) begin
        if (mem_done) begin
          m_busy = 1'b0;
          m_rd   = 1'b0;
          m_wr   = 1'b0;
        end
      end else if (pend_i || pend_l) begin
        m_busy = 1'b1;
        if (pend_i && (!pend_l || m_wait >= MAX_WAIT)) begin
          m_owner = 1'b0;
          m_addr  = ifu_address & ~64'h3;
          m_size  = 2'd2;
          m_rd    = 1'b1;
          m_wr    = 1'b0;
          m_wv    = 1'b0;
          m_wait  = 0;
        end else begin
          m_owner = 1'b1;
          m_addr  = lsu_address;
          m_size  = lsu_datasize;
          m_rd    = lsu_read;
          m_wr    = lsu_write && !lsu_read;
          m_wdata = lsu_writedata;
          m_wv    = 1'b1;
          if (pend_i) m_wait = (m_wait + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_wait + 1;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the bus adapter's single mem_* command port.
- Shares that port between the instruction fetch unit (IFU, tetra reads only) and the load/store unit (LSU, byte/wyde/tetra/octa reads and writes).
- Serialises transactions with a grant-locked state machine: one outstanding transaction, owner fixed until mem_done.
- Arbitration is LSU-priority with an IFU starvation guard.

Parameters:
- MAX_WAIT, 4: consecutive lost arbitrations after which a pending IFU request wins the next arbitration; range 1..15.
- CNT_W, 4: width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ifu_read  in  1  IFU fetch request; held with ifu_address until ifu_done
- ifu_address  in  64  fetch address; bits [1:0] ignored
- ifu_readdata  out  32  fetched tetra; valid only while ifu_done=1
- ifu_done  out  1  one-cycle completion pulse to IFU
- lsu_read  in  1  LSU load request
- lsu_write  in  1  LSU store request
- lsu_address  in  64  load/store address
- lsu_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- lsu_writedata  in  64  right-justified store data
- lsu_readdata  out  64  load data; valid only while lsu_done=1
- lsu_done  out  1  one-cycle completion pulse to LSU
- mem_address  out  64  to bus adapter
- mem_datasize  out  2  to bus adapter
- mem_read  out  1  to bus adapter
- mem_write  out  1  to bus adapter
- mem_writedata  out  64  to bus adapter
- mem_readdata  in  64  right-justified read data from bus adapter
- mem_done  in  1  completion pulse from bus adapter
- owner  out  1  0 = IFU, 1 = LSU; meaningful while busy=1
- busy  out  1  transaction in flight

Behaviour:
- Reset state: IDLE.
  - Outputs low/zero: mem_read, mem_write, mem_address, mem_datasize, mem_writedata, owner, busy, ifu_done, lsu_done.
  - Starvation counter = 0.
- Reset mid-transaction: abandons the transaction and issues no done pulse. The bus adapter shares reset_n.
- All mem_* outputs, owner and busy are registered. ifu_done, lsu_done and both readdata outputs are combinational.
- Request qualification:
  - pend_i = ifu_read.
  - pend_l = lsu_read | lsu_write.
  - lsu_read & lsu_write both high: treated as a read.
- IDLE, no pending request: stay in IDLE.
- IDLE, pend_i or pend_l sampled at edge t:
  - Winner selection:
    - If pend_i and (!pend_l or wait_cnt >= MAX_WAIT): IFU wins.
    - Otherwise LSU wins.
  - At edge t, the winner's command is latched into the mem_* registers:
    - IFU: address {ifu_address[63:2], 2'b00}, datasize 2, mem_read=1.
    - LSU: lsu_address, lsu_datasize, lsu_writedata, mem_read=lsu_read, mem_write=lsu_write & ~lsu_read.
  - owner and busy=1 are set at the same edge; next state is BUSY.
  - mem_read/mem_write are therefore high from cycle t+1.
- Starvation counter, updated at each grant edge:
  - LSU wins while pend_i: wait_cnt+1, saturating at 2^CNT_W-1.
  - IFU wins: wait_cnt cleared.
  - LSU wins with no IFU pending: unchanged.
- BUSY:
  - mem_* outputs hold constant; requester inputs are not re-sampled.
  - While mem_done=1: the owner's done = 1 and its readdata is driven.
    - ifu_readdata = mem_readdata[31:0].
    - lsu_readdata = mem_readdata.
  - At the edge sampling mem_done=1: clear mem_read, mem_write and busy; next state IDLE.
- Idle gap: IDLE always lasts at least one cycle. This guarantees mem_read/mem_write are low for at least one cycle between transactions, as the bus adapter's restart behaviour requires.
- Back-to-back requests: a requester that keeps its request high in the cycle after its done is treated as a new request. Requesters drop the request at the done edge unless they intend to reissue.
- mem_done in IDLE: ignored; no done pulse to either requester.
- Non-owner done output: always 0.
- Request changed or dropped during BUSY: no effect on the in-flight transaction.
- Throughput: one transaction per (adapter latency + 1) cycles; arbitration adds exactly 1 cycle of latency.

Test Plan:
- Reset:
  - Stimulus: assert reset_n=0 with ifu_read=1.
  - Response: all outputs 0; after release, mem_read=1 with mem_address=0x...00 one cycle later.
- Single IFU fetch:
  - Stimulus: ifu_address=0x1003, mem_done pulsed 3 cycles after mem_read rises, mem_readdata=0x00000000_DEADBEEF.
  - Response: mem_address=0x1000, mem_datasize=2; ifu_done=1 for exactly that cycle with ifu_readdata=0xDEADBEEF; lsu_done=0.
- LSU store:
  - Stimulus: lsu_write=1, lsu_datasize=1, lsu_address=0x2006, lsu_writedata=0xABCD.
  - Response: mem_write=1, mem_read=0, fields match; lsu_done on mem_done; mem_write low the following cycle; busy=0.
- Simultaneous requests:
  - Stimulus: ifu_read and lsu_read both held continuously, MAX_WAIT=4.
  - Response: grant sequence LSU,LSU,LSU,LSU,IFU,LSU…; owner matches; at least one idle cycle between every mem_read pulse.
- Spurious and late inputs:
  - Stimulus: mem_done pulsed in IDLE.
  - Response: no done pulse to either requester.
  - Stimulus: lsu_address changed mid-BUSY.
  - Response: mem_address unchanged.
- Abort:
  - Stimulus: reset mid-BUSY.
  - Response: mem_read drops immediately, no done pulse; a fresh request is arbitrated normally after reset release.
